// File: rtl/vga_pkg.sv
// Shared constants and types for the 280x192 framebuffer.
package vga_pkg;

   localparam int FB_W = 280;
   localparam int FB_H = 192;
   localparam int FB_PIXELS = FB_W * FB_H;
   localparam logic [15:0] PAL_BASE = 16'hFF00;
   localparam logic [15:0] CLEAR_ADR = 16'hFF40;

   typedef logic [23:0] rgb_t;
   typedef logic [3:0] pix_t;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

endpackage

// File: rtl/vga_framebuffer_ram.sv
// Frame store: one write port, one read port.
// A read colliding with a write returns the old contents.
import vga_pkg::*;

module fb_ram #(
   parameter int DEPTH = FB_PIXELS
) (
   input  logic        clk,
   input  logic        we,
   input  logic [15:0] wa,
   input  pix_t        wd,
   input  logic [15:0] ra,
   output pix_t        rd
);

   pix_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      rd <= mem[ra];
   end

endmodule

// File: rtl/vga_framebuffer.sv
// 4bpp frame store with 16-entry palette, CPU write port and
// hardware frame fill; two-stage registered video read path.
import vga_pkg::*;

module vga_framebuffer #(
   parameter logic [15:0] FB_PIXELS = 16'(vga_pkg::FB_PIXELS),
   parameter logic [15:0] PAL_BASE  = vga_pkg::PAL_BASE,
   parameter logic [15:0] CLEAR_ADR = vga_pkg::CLEAR_ADR
) (
   input  logic        clock_50,
   input  logic        reset,
   input  logic [15:0] adr,
   output rgb_t        d,
   input  logic [15:0] cpu_adr,
   input  logic [7:0]  cpu_dat,
   input  logic        cpu_valid,
   output logic        cpu_ready
);

   localparam logic [15:0] PAL_END = PAL_BASE + 16'd48;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   pix_t        fill, fill_n;
   rgb_t        pal [16];

   logic        acc, pix_hit, pal_hit, clr_hit;
   logic [5:0]  off;
   logic [3:0]  ent;
   logic [1:0]  comp;

   logic        we;
   logic [15:0] wa;
   pix_t        wd;
   pix_t        idx;
   logic        oor;

   assign cpu_ready = (state == IDLE);
   assign acc = cpu_valid & cpu_ready;
   assign pix_hit = acc && (cpu_adr < FB_PIXELS);
   assign pal_hit = acc && (cpu_adr >= PAL_BASE)
                        && (cpu_adr < PAL_END);
   assign clr_hit = acc && (cpu_adr == CLEAR_ADR);

   assign off = 6'(cpu_adr - PAL_BASE);
   assign ent = 4'(off / 6'd3);
   assign comp = 2'(off % 6'd3);

   // The fill owns the write port while it runs.
   always_comb begin
      we = pix_hit;
      wa = cpu_adr;
      wd = cpu_dat[3:0];
      if (state == CLEAR) begin
         we = 1'b1;
         wa = cnt;
         wd = fill;
      end
   end

   fb_ram #(
      .DEPTH(int'(FB_PIXELS))
   ) u_ram (
      .clk(clock_50),
      .we (we),
      .wa (wa),
      .wd (wd),
      .ra (adr),
      .rd (idx)
   );

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      fill_n = fill;
      unique case (state)
         IDLE: begin
            if (clr_hit) begin
               state_n = CLEAR;
               fill_n = cpu_dat[3:0];
               cnt_n = 16'd0;
            end
         end
         CLEAR: begin
            if (cnt == FB_PIXELS - 16'd1) begin
               state_n = IDLE;
               cnt_n = 16'd0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= 16'd0;
         fill <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         fill <= fill_n;
      end
   end

   // Grayscale ramp at reset: entry i = {ii,ii,ii}.
   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++)
            pal[i] <= {3{8'(17 * i)}};
      end else if (pal_hit) begin
         unique case (comp)
            2'd0: pal[ent][23:16] <= cpu_dat;
            2'd1: pal[ent][15:8] <= cpu_dat;
            2'd2: pal[ent][7:0] <= cpu_dat;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         oor <= 1'b0;
         d <= '0;
      end else begin
         oor <= (adr >= FB_PIXELS);
         d <= oor ? '0 : pal[idx];
      end
   end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Bench for vga_framebuffer: vector table, directed corner
// sequences and randomized traffic against a reference model.
module tb_vga_framebuffer;
   import vga_pkg::*;

   logic        clock_50 = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] adr = '0;
   logic [23:0] d;
   logic [15:0] cpu_adr = '0;
   logic [7:0]  cpu_dat = '0;
   logic        cpu_valid = 1'b0;
   logic        cpu_ready;

   int total = 0;
   int passed = 0;

   logic [3:0]  pix_m [FB_PIXELS];
   logic [23:0] pal_m [16];
   logic [15:0] q [$];

   typedef struct packed {
      logic [15:0] wa;
      logic [7:0]  wd;
      logic [15:0] ra;
      logic [23:0] exp;
   } vec_t;

   vec_t vt [12];

   vga_framebuffer dut (
      .clock_50 (clock_50),
      .reset    (reset),
      .adr      (adr),
      .d        (d),
      .cpu_adr  (cpu_adr),
      .cpu_dat  (cpu_dat),
      .cpu_valid(cpu_valid),
      .cpu_ready(cpu_ready)
   );

   always #5 clock_50 = ~clock_50;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [23:0] gray(input int v);
      return {3{8'(v * 17)}};
   endfunction

   function automatic logic [23:0] expect_d(input logic [15:0] a);
      if (int'(a) >= FB_PIXELS) return 24'h0;
      return pal_m[pix_m[a]];
   endfunction

   task automatic model_wr(input logic [15:0] a, input logic [7:0] v);
      int ai;
      int k;
      ai = int'(a);
      if (ai < FB_PIXELS) begin
         pix_m[a] = v[3:0];
      end else if (ai >= int'(PAL_BASE) && ai < int'(PAL_BASE) + 48) begin
         k = ai - int'(PAL_BASE);
         pal_m[k / 3][23 - 8 * (k % 3) -: 8] = v;
      end
   endtask

   task automatic chk(input string nm, input logic [23:0] act,
                      input logic [23:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %06h want %06h", nm, act, exp);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] v);
      int n;
      n = 0;
      cpu_adr = a;
      cpu_dat = v;
      cpu_valid = 1'b1;
      while (!cpu_ready && n < 70000) begin
         @(posedge clock_50);
         #1;
         n++;
      end
      if (n >= 70000) begin
         total++;
         $display("FAIL wr_timeout: got %0d cycles want ready", n);
      end
      @(posedge clock_50);
      #1;
      cpu_valid = 1'b0;
      model_wr(a, v);
   endtask

   task automatic look(input logic [15:0] a, input string nm,
                       input logic [23:0] exp);
      adr = a;
      repeat (3) @(posedge clock_50);
      #1;
      chk(nm, d, exp);
   endtask

   initial begin
      int n;
      int op;
      logic [15:0] a;

      vt[0]  = '{16'h0005, 8'h0F, 16'h0005, 24'hFFFFFF};
      vt[1]  = '{16'hFF03, 8'h12, 16'h0005, 24'hFFFFFF};
      vt[2]  = '{16'hFF04, 8'h34, 16'h0005, 24'hFFFFFF};
      vt[3]  = '{16'hFF05, 8'h56, 16'h0005, 24'hFFFFFF};
      vt[4]  = '{16'h0064, 8'hF1, 16'h0064, 24'h123456};
      vt[5]  = '{16'hFF03, 8'hAA, 16'h0064, 24'hAA3456};
      vt[6]  = '{16'hD200, 8'h03, 16'hD200, 24'h000000};
      vt[7]  = '{16'hE000, 8'h05, 16'hFFFF, 24'h000000};
      vt[8]  = '{16'hFF30, 8'h77, 16'h0064, 24'hAA3456};
      vt[9]  = '{16'hD1FF, 8'h0E, 16'hD1FF, 24'hEEEEEE};
      vt[10] = '{16'hFF2F, 8'h9A, 16'h0005, 24'hFFFF9A};
      vt[11] = '{16'h0000, 8'h00, 16'h0000, 24'h000000};

      for (int i = 0; i < 16; i++) pal_m[i] = gray(i);

      #1;
      chk("rst_d", d, 24'h0);
      chk("rst_ready", {23'b0, cpu_ready}, 24'h1);
      repeat (3) @(posedge clock_50);
      #1;
      reset = 1'b1;
      @(posedge clock_50);
      #1;
      chk("rel_ready", {23'b0, cpu_ready}, 24'h1);

      for (int i = 0; i < 12; i++) begin
         wr(vt[i].wa, vt[i].wd);
         look(vt[i].ra, $sformatf("vec%0d", i), vt[i].exp);
      end

      look(16'd100, "pal_pre", 24'hAA3456);
      wr(16'hFF03, 8'hC3);
      chk("pal_old", d, 24'hAA3456);
      @(posedge clock_50);
      #1;
      chk("pal_new", d, 24'hC33456);

      wr(16'd7, 8'h01);
      look(16'd7, "col_pre", 24'hC33456);
      wr(16'd7, 8'h03);
      @(posedge clock_50);
      #1;
      chk("col_old", d, 24'hC33456);
      @(posedge clock_50);
      #1;
      chk("col_new", d, 24'h333333);

      wr(CLEAR_ADR, 8'h02);
      chk("fill_busy", {23'b0, cpu_ready}, 24'h0);
      cpu_adr = 16'd300;
      cpu_dat = 8'h05;
      cpu_valid = 1'b1;
      n = 0;
      while (!cpu_ready && n < 60000) begin
         @(posedge clock_50);
         #1;
         n++;
      end
      chk("fill_len", 24'(n), 24'd53760);
      @(posedge clock_50);
      #1;
      cpu_valid = 1'b0;
      for (int i = 0; i < FB_PIXELS; i++) pix_m[i] = 4'h2;
      pix_m[300] = 4'h5;

      look(16'd0, "fill_0", 24'h222222);
      look(16'd280, "fill_280", 24'h222222);
      look(16'd53759, "fill_last", 24'h222222);
      look(16'd100, "fill_100", 24'h222222);
      look(16'd300, "held_wr", 24'h555555);

      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 9));
         if (op < 4) begin
            a = 16'($urandom_range(0, FB_PIXELS - 1));
            wr(a, 8'($urandom));
            q.push_back(a);
         end else if (op < 6) begin
            a = 16'(int'(PAL_BASE) + int'($urandom_range(0, 47)));
            wr(a, 8'($urandom));
         end else begin
            if (op == 9)
               a = 16'($urandom_range(FB_PIXELS, 65535));
            else if (q.size() > 0 && op < 8)
               a = q[$urandom_range(0, q.size() - 1)];
            else
               a = 16'($urandom_range(0, FB_PIXELS - 1));
            look(a, "rand", expect_d(a));
         end
      end

      wr(CLEAR_ADR, 8'h09);
      repeat (1000) @(posedge clock_50);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", {23'b0, cpu_ready}, 24'h1);
      chk("mid_rst_d", d, 24'h0);
      repeat (2) @(posedge clock_50);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 16; i++) pal_m[i] = gray(i);
      for (int i = 0; i < 1000; i++) pix_m[i] = 4'h9;
      @(posedge clock_50);
      #1;
      chk("mid_idle", {23'b0, cpu_ready}, 24'h1);
      look(16'd0, "mid_0", 24'h999999);
      look(16'd999, "mid_999", 24'h999999);
      look(16'd1000, "mid_1000", expect_d(16'd1000));
      wr(16'd1000, 8'h04);
      look(16'd1000, "mid_wr", 24'h444444);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
